// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the single-cycle core.
// This block owns the PC register and the IDLE/RUN/HALTED state machine.
// The PC steps sequentially or jumps to absolute targets from the
// branch-target LUT, and completion is reported through start/done.
// Optional feature: define PC_WATCHDOG_EN to build a RUN-cycle watchdog
// that forces HALTED with err set after MAX_CYCLES RUN cycles.
module pc_sequencer #(
  parameter int D          = 12,
  parameter int A          = 5,
  parameter int START_PC   = 0,
  parameter int MAX_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         br_en,
  input  logic         br_cond,
  input  logic [A-1:0] br_idx,
  output logic [A-1:0] lut_addr,
  input  logic [D-1:0] lut_target,
  output logic [D-1:0] pc,
  output logic         br_taken,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [D-1:0] StartPc = D'(START_PC);

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         br_taken_q, br_taken_d;
  logic         err_q, err_d;

`ifdef PC_WATCHDOG_EN
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] WdgLast = CW'(MAX_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_max_cycles;
  assign unused_max_cycles = (MAX_CYCLES > 0);
`endif

  // LUT address follows the index field only for branch instructions so the LUT idles at entry 0
  always_comb begin
    lut_addr = '0;
    if (br_en) begin
      lut_addr = br_idx;
    end
  end

  // Next-state logic for the FSM, PC, branch pulse, sticky error and optional watchdog
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    br_taken_d = 1'b0;
    err_d      = err_q;
`ifdef PC_WATCHDOG_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = StartPc;
          err_d   = 1'b0;
`ifdef PC_WATCHDOG_EN
          cnt_d   = '0;
`endif
        end
      end

      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = HALTED;
          end else if (br_en && br_cond && (br_idx == '0)) begin
            state_d = HALTED;
            err_d   = 1'b1;
          end else if (br_en && br_cond) begin
            pc_d       = lut_target;
            br_taken_d = 1'b1;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
`ifdef PC_WATCHDOG_EN
        // Stalled cycles still count; the MAX_CYCLES-th RUN cycle trips the watchdog
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == WdgLast) begin
          state_d    = HALTED;
          pc_d       = pc_q;
          br_taken_d = 1'b0;
          err_d      = 1'b1;
        end
`endif
      end

      HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = StartPc;
          err_d   = 1'b0;
`ifdef PC_WATCHDOG_EN
          cnt_d   = '0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        pc_d    = StartPc;
        err_d   = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset that overrides every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= StartPc;
      br_taken_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef PC_WATCHDOG_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      br_taken_q <= br_taken_d;
      err_q      <= err_d;
`ifdef PC_WATCHDOG_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign br_taken = br_taken_q;
  assign err      = err_q;
  assign done     = (state_q == HALTED);

endmodule
